// File: rtl/pl_exmem_stage.sv
// EX/MEM pipeline register with architectural status flags, EX->EX forwarding
// and load-use hazard detection for the ID stage.
module pl_exmem_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_dout,
  input  logic              ex_cout,
  input  logic              ex_gt,
  input  logic              ex_lt,
  input  logic              ex_eq,
  input  logic              ex_cmp,
  input  logic              ex_c_upd,
  input  logic              ex_wb_en,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_mem_wr,
  input  logic              ex_mem_rd,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic [RD_W-1:0]   id_rs1,
  input  logic [RD_W-1:0]   id_rs2,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic              mem_wb_en,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_wr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              flag_c,
  output logic              flag_gt,
  output logic              flag_lt,
  output logic              flag_eq,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic              load_use
);

  logic capture;
  logic rs1_match;
  logic rs2_match;

  assign capture = ~flush & ~stall;

  // Control bits are cleared by flush even under stall; data registers hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid   <= 1'b0;
      mem_wb_en   <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_result  <= '0;
      mem_rd      <= '0;
      mem_addr    <= '0;
      mem_st_data <= '0;
    end else if (flush) begin
      mem_valid   <= 1'b0;
      mem_wb_en   <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd_en   <= 1'b0;
    end else if (!stall) begin
      mem_valid   <= ex_valid;
      mem_wb_en   <= ex_wb_en & ex_valid;
      mem_wr      <= ex_mem_wr & ex_valid;
      mem_rd_en   <= ex_mem_rd & ex_valid;
      mem_result  <= ex_dout;
      mem_rd      <= ex_rd;
      mem_addr    <= ex_addr;
      mem_st_data <= ex_st_data;
    end
  end

  // Status flags only change on a real, captured instruction; flush never clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c  <= 1'b0;
      flag_gt <= 1'b0;
      flag_lt <= 1'b0;
      flag_eq <= 1'b0;
    end else if (capture && ex_valid) begin
      if (ex_cmp) begin
        flag_gt <= ex_gt;
        flag_lt <= ex_lt;
        flag_eq <= ex_eq;
      end
      if (ex_c_upd) begin
        flag_c <= ex_cout;
      end
    end
  end

  assign rs1_match = (mem_rd == id_rs1);
  assign rs2_match = (mem_rd == id_rs2);

  // A load result is not available yet, so it raises load_use instead of forwarding.
  assign fwd_hit1 = mem_valid & mem_wb_en & ~mem_rd_en & rs1_match;
  assign fwd_hit2 = mem_valid & mem_wb_en & ~mem_rd_en & rs2_match;
  assign load_use = mem_valid & mem_rd_en & mem_wb_en & (rs1_match | rs2_match);

endmodule
